// File: rtl/vga_overlay_out.sv
// rtl/vga_overlay_out.sv - registered VGA DAC output stage with underflow capture.
// Macro VGA_OVERLAY_CURSOR_EN compiles in the crosshair cursor overlay.
module vga_overlay_out #(
  parameter int          CURSOR_HALF  = 8,
  parameter logic [23:0] CURSOR_COLOR = 24'hFF0000,
  parameter int          CNT_W        = 11
) (
  input  logic             vid_clk,
  input  logic             reset,
  input  logic [23:0]      vid_data,
  input  logic             vid_datavalid,
  input  logic             vid_h_sync,
  input  logic             vid_v_sync,
  input  logic             vid_underflow,
  input  logic [CNT_W-1:0] cursor_x,
  input  logic [CNT_W-1:0] cursor_y,
  input  logic             cursor_wr,
  input  logic             cursor_en,
  input  logic             uflow_clr,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             vga_hs_n,
  output logic             vga_vs_n,
  output logic             vga_blank_n,
  output logic             vga_sync_n,
  output logic             vga_clk,
  output logic             uflow_sticky,
  output logic [15:0]      uflow_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [23:0]      s1_data_q;
  logic             s1_dv_q, s1_hs_q, s1_vs_q, s1_uf_q;
  logic             dv_dly_q, vs_dly_q, uf_dly_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             line_end, vs_rise, uf_rise;
  logic             overlay;
  logic [23:0]      rgb_q, rgb_d;
  logic             blank_q, hs_n_q, vs_n_q;
  logic             sticky_q, sticky_d;
  logic [15:0]      count_q, count_d;

  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      s1_data_q <= '0;
      s1_dv_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_uf_q   <= 1'b0;
      dv_dly_q  <= 1'b0;
      vs_dly_q  <= 1'b0;
      uf_dly_q  <= 1'b0;
    end else begin
      s1_data_q <= vid_data;
      s1_dv_q   <= vid_datavalid;
      s1_hs_q   <= vid_h_sync;
      s1_vs_q   <= vid_v_sync;
      s1_uf_q   <= vid_underflow;
      dv_dly_q  <= s1_dv_q;
      vs_dly_q  <= s1_vs_q;
      uf_dly_q  <= s1_uf_q;
    end
  end

  assign line_end = ~s1_dv_q & dv_dly_q;
  assign vs_rise  = s1_vs_q & ~vs_dly_q;
  assign uf_rise  = s1_uf_q & ~uf_dly_q;

  // x_q/y_q hold the position of the pixel currently in stage 1.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (s1_dv_q) begin
      if (x_q != CNT_MAX) x_d = x_q + 1'b1;
    end else if (line_end) begin
      x_d = '0;
    end
    if (vs_rise) begin
      y_d = '0;
    end else if (line_end && (y_q != CNT_MAX)) begin
      y_d = y_q + 1'b1;
    end
  end

  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

`ifdef VGA_OVERLAY_CURSOR_EN
  localparam logic [CNT_W:0] HALF_W = (CNT_W+1)'(CURSOR_HALF);

  logic [CNT_W-1:0]      pend_x_q, pend_y_q, act_x_q, act_y_q;
  logic signed [CNT_W:0] dx, dy;
  logic [CNT_W:0]        adx, ady;
  logic                  hit;

  // Active cursor only changes at vsync so a frame never shows two positions.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      pend_x_q <= '0;
      pend_y_q <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
    end else begin
      if (cursor_wr) begin
        pend_x_q <= cursor_x;
        pend_y_q <= cursor_y;
      end
      if (vs_rise) begin
        act_x_q <= pend_x_q;
        act_y_q <= pend_y_q;
      end
    end
  end

  always_comb begin
    dx  = $signed({1'b0, x_q}) - $signed({1'b0, act_x_q});
    dy  = $signed({1'b0, y_q}) - $signed({1'b0, act_y_q});
    adx = dx[CNT_W] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[CNT_W] ? $unsigned(-dy) : $unsigned(dy);
    hit = ((y_q == act_y_q) && (adx <= HALF_W)) ||
          ((x_q == act_x_q) && (ady <= HALF_W));
  end

  assign overlay = cursor_en & hit;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x, cursor_y, cursor_wr, cursor_en};
  assign overlay       = 1'b0;
`endif

  always_comb begin
    rgb_d = 24'h0;
    if (s1_dv_q) rgb_d = overlay ? CURSOR_COLOR : s1_data_q;
  end

  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (uflow_clr) begin
      sticky_d = 1'b0;
      count_d  = 16'h0;
    end else if (uf_rise) begin
      sticky_d = 1'b1;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      rgb_q    <= 24'h0;
      blank_q  <= 1'b0;
      hs_n_q   <= 1'b1;
      vs_n_q   <= 1'b1;
      sticky_q <= 1'b0;
      count_q  <= 16'h0;
    end else begin
      rgb_q    <= rgb_d;
      blank_q  <= s1_dv_q;
      hs_n_q   <= ~s1_hs_q;
      vs_n_q   <= ~s1_vs_q;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign vga_r        = rgb_q[23:16];
  assign vga_g        = rgb_q[15:8];
  assign vga_b        = rgb_q[7:0];
  assign vga_blank_n  = blank_q;
  assign vga_hs_n     = hs_n_q;
  assign vga_vs_n     = vs_n_q;
  assign vga_sync_n   = 1'b0;
  assign vga_clk      = vid_clk;
  assign uflow_sticky = sticky_q;
  assign uflow_count  = count_q;

endmodule

// File: tb/tb_vga_overlay_out.sv
// tb/tb_vga_overlay_out.sv - scoreboard bench for vga_overlay_out on a reduced video timing.
// Expected overlay depends on VGA_OVERLAY_CURSOR_EN matching the RTL build.
module tb_vga_overlay_out;

`ifdef VGA_OVERLAY_CURSOR_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam int          H_ACT = 112, H_TOT = 124, V_ACT = 60, V_TOT = 64;
  localparam int          HALF  = 8;
  localparam logic [23:0] COLOR = 24'hFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] vid_data;
  logic        vid_datavalid, vid_h_sync, vid_v_sync, vid_underflow;
  logic [10:0] cursor_x, cursor_y;
  logic        cursor_wr, cursor_en, uflow_clr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs_n, vga_vs_n, vga_blank_n, vga_sync_n, vga_clk;
  logic        uflow_sticky;
  logic [15:0] uflow_count;

  vga_overlay_out dut (
    .vid_clk(clk), .reset(reset), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_underflow(vid_underflow),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_wr(cursor_wr), .cursor_en(cursor_en),
    .uflow_clr(uflow_clr), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_clk(vga_clk), .uflow_sticky(uflow_sticky),
    .uflow_count(uflow_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          hitcnt = 0;
  bit          chk_en = 1'b0;
  logic [28:0] exp_q[$];
  int          m_px = 0, m_py = 0, m_ax = 0, m_ay = 0;
  int          exp_hits[5] = '{0, 33, 22, 33, 33};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int iabs(input int d);
    return (d < 0) ? -d : d;
  endfunction

  function automatic bit hit(input int x, input int y, input int cx, input int cy);
    return ((y == cy) && (iabs(x - cx) <= HALF)) || ((x == cx) && (iabs(y - cy) <= HALF));
  endfunction

  // Monitor: outputs lag inputs by two cycles, so one entry stays queued.
  initial begin
    logic [28:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en && exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        chk("pix", {3'b0, vga_r, vga_g, vga_b, vga_blank_n, vga_hs_n, vga_vs_n, vga_sync_n, vga_clk},
            {3'b0, e});
        if (vga_blank_n && ({vga_r, vga_g, vga_b} == COLOR)) hitcnt++;
      end
    end
  end

  task automatic wr_cursor(input int x, input int y);
    cursor_wr = 1'b1;
    cursor_x  = 11'(x);
    cursor_y  = 11'(y);
    m_px = x;
    m_py = y;
  endtask

  task automatic run_frame(input int f);
    logic [23:0] e_rgb;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        @(posedge clk);
        #2;
        vid_datavalid = (v < V_ACT) && (h < H_ACT);
        vid_data      = {8'(h), 8'(v), 8'(h + v + f)};
        vid_h_sync    = (h >= H_ACT + 2) && (h < H_ACT + 6);
        vid_v_sync    = (v == V_ACT + 1) || (v == V_ACT + 2);
        cursor_wr     = 1'b0;
        uflow_clr     = 1'b0;
        vid_underflow = 1'b0;
        if (v == V_ACT + 1 && h == 0) begin
          chk("hits", 32'(hitcnt), OVL ? 32'(exp_hits[f]) : 32'd0);
          hitcnt = 0;
        end
        if (v == V_ACT + 1 && h == 1) begin
          m_ax = m_px;
          m_ay = m_py;
        end
        if (f == 0 && v == 10 && h == 50) wr_cursor(100, 50);
        if (f == 1 && v == 30 && h == 20) wr_cursor(3, 2);
        if (f == 2 && v == 20 && h == 5) wr_cursor(60, 40);
        if (f == 2 && v == V_ACT + 1 && h == 1) wr_cursor(20, 30);
        if (f == 0 && v == V_ACT + 3 && h == 0) cursor_en = 1'b1;
        if (f == 0 && (v >= 5 && v <= 7) && (h == 10 || h == 11)) vid_underflow = 1'b1;
        if (f == 0 && v == 10 && h == 0) begin
          chk("uflow_count3", 32'(uflow_count), 32'd3);
          chk("uflow_sticky3", 32'(uflow_sticky), 32'd1);
        end
        if (f == 1 && v == 5 && h == 10) vid_underflow = 1'b1;
        if (f == 1 && v == 5 && h == 11) uflow_clr = 1'b1;
        if (f == 1 && v == 8 && h == 0) begin
          chk("uflow_count_clr", 32'(uflow_count), 32'd0);
          chk("uflow_sticky_clr", 32'(uflow_sticky), 32'd0);
        end
        if (f == 1 && v == 9 && h == 10) vid_underflow = 1'b1;
        if (f == 1 && v == 12 && h == 0) begin
          chk("uflow_count_after", 32'(uflow_count), 32'd1);
          chk("uflow_sticky_after", 32'(uflow_sticky), 32'd1);
        end
        e_rgb = 24'h0;
        if (vid_datavalid)
          e_rgb = (OVL && cursor_en && hit(h, v, m_ax, m_ay)) ? COLOR : vid_data;
        exp_q.push_back({e_rgb, vid_datavalid, ~vid_h_sync, ~vid_v_sync, 1'b0, 1'b1});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    vid_data = 24'hFFFFFF; vid_datavalid = 1'b1; vid_h_sync = 1'b1; vid_v_sync = 1'b1;
    vid_underflow = 1'b1; cursor_x = 11'd5; cursor_y = 11'd5; cursor_wr = 1'b1;
    cursor_en = 1'b0; uflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rgb", {8'b0, vga_r, vga_g, vga_b}, 32'h0);
    chk("rst_blank_n", 32'(vga_blank_n), 32'd0);
    chk("rst_hs_n", 32'(vga_hs_n), 32'd1);
    chk("rst_vs_n", 32'(vga_vs_n), 32'd1);
    chk("rst_sticky", 32'(uflow_sticky), 32'd0);
    chk("rst_count", 32'(uflow_count), 32'd0);
    vid_data = 24'h0; vid_datavalid = 1'b0; vid_h_sync = 1'b0; vid_v_sync = 1'b0;
    vid_underflow = 1'b0; cursor_wr = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    for (int f = 0; f < 5; f++) run_frame(f);
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      vid_datavalid = 1'b1; vid_data = 24'h123456; vid_h_sync = 1'b1;
    end
    @(posedge clk);
    #3;
    chk("pre_rst_blank_n", 32'(vga_blank_n), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rgb", {8'b0, vga_r, vga_g, vga_b}, 32'h0);
    chk("mid_rst_blank_n", 32'(vga_blank_n), 32'd0);
    chk("mid_rst_hs_n", 32'(vga_hs_n), 32'd1);
    chk("mid_rst_count", 32'(uflow_count), 32'd0);
    chk("mid_rst_sticky", 32'(uflow_sticky), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_overlay_out.md
# vga_overlay_out

Output stage directly downstream of the system's clocked-video output (24-bit RGB, datavalid, h/v sync, underflow). Tracks pixel position from the video timing stream, optionally overlays a crosshair cursor at the current touch coordinate, and drives the VGA DAC pins with registered, glitch-free signals. Also records frame-buffer underflow events for software debug.

## Interface
Parameters:
- `CURSOR_HALF`, 8: crosshair arm length in pixels; range 0–63.
- `CURSOR_COLOR`, 24'hFF0000: overlay RGB value, as {R,G,B}.
- `CNT_W`, 11: pixel x/y counter width.

Ports:
- `vid_clk` in 1: pixel clock; same clock as the clocked-video output.
- `reset` in 1: asynchronous, active-high.
- `vid_data` in 24: RGB pixel, {R[23:16],G[15:8],B[7:0]}.
- `vid_datavalid` in 1: active-picture qualifier.
- `vid_h_sync` in 1: active-high hsync.
- `vid_v_sync` in 1: active-high vsync.
- `vid_underflow` in 1: upstream frame-buffer underflow.
- `cursor_x` in CNT_W: new cursor column.
- `cursor_y` in CNT_W: new cursor row.
- `cursor_wr` in 1: one-cycle strobe that loads `cursor_x`/`cursor_y` into the pending registers.
- `cursor_en` in 1: overlay enable, level-sensitive.
- `uflow_clr` in 1: clears `uflow_sticky` and `uflow_count`.
- `vga_r`, `vga_g`, `vga_b` out 8 each: DAC colour.
- `vga_hs_n`, `vga_vs_n` out 1 each: active-low syncs.
- `vga_blank_n` out 1: high during active picture.
- `vga_sync_n` out 1: held at constant 0.
- `vga_clk` out 1: equals `vid_clk`, forwarded combinationally.
- `uflow_sticky` out 1: set on any underflow.
- `uflow_count` out 16: count of underflow rising edges, saturating.

## Operation
- **Stage 1** registers every `vid_*` input. A 1-cycle-delayed copy of datavalid and vsync is kept for edge detection.
- **x counter**
  - Increments on each stage-1 valid cycle.
  - Clears to 0 on the first invalid cycle after a valid one (line end).
  - Saturates at 2^CNT_W−1.
- **y counter**
  - Increments at each line end.
  - Clears to 0 on the vsync rising edge.
  - Saturates at 2^CNT_W−1.
- **Cursor registers**
  - `cursor_wr` loads the pending registers.
  - On the vsync rising edge, pending is copied to active. Updates therefore never tear mid-frame.
  - If `cursor_wr` and the vsync rising edge occur in the same cycle, active takes the old pending value; the new value takes effect next frame.
- **Hit test** (stage 2):
  - hit = (y==cy and |x−cx|≤CURSOR_HALF) or (x==cx and |y−cy|≤CURSOR_HALF).
  - Differences use CNT_W+1-bit signed arithmetic, so there is no wrap near 0.
- **Stage 2 output**
  - RGB = CURSOR_COLOR when valid and hit and `cursor_en`; otherwise the pixel from stage 1.
  - RGB is forced to 0 when not valid.
  - `vga_blank_n` = valid; `vga_hs_n` = ~hsync; `vga_vs_n` = ~vsync.
- **Underflow**
  - A rising edge of the registered `vid_underflow` sets the sticky flag and increments the count (saturates at 16'hFFFF).
  - `uflow_clr` has priority over an edge arriving in the same cycle; that edge is lost.

## Timing
- Latency is 2 `vid_clk` cycles from input to all VGA outputs. Every output is registered, and sync, blank and colour stay aligned.
- Reset values:
  - RGB = 0, `vga_blank_n` = 0, `vga_hs_n` = 1, `vga_vs_n` = 1.
  - Counters = 0; pending and active cursor = 0.
  - `uflow_sticky` = 0, `uflow_count` = 0.
- Reset asserted mid-frame: all outputs return to their reset values immediately. After release, y is not valid until the next vsync edge, while x realigns at the first line end. Pixel data still passes through.
- No handshake. The upstream stream cannot be stalled, so the block accepts every cycle.

## Configuration
- `VGA_OVERLAY_CURSOR_EN` defined: cursor registers, hit test and overlay mux are compiled in.
- Not defined:
  - The block is a pure 2-stage passthrough; `cursor_*` inputs are ignored.
  - x/y counters are still present.
  - Latency stays 2 cycles.

## Test plan
- **Reset/passthrough:** release reset, drive a 640×480 timing with ramp data and `cursor_en`=0 → outputs equal the input delayed 2 cycles; RGB=0 wherever datavalid=0; hs_n/vs_n are inverted input syncs.
- **Crosshair:** cursor (100,50), HALF=8, write, one vsync, `cursor_en`=1 → CURSOR_COLOR on row 50 for x 92–108 and column 100 for y 42–58; all other pixels unchanged.
- **Edge clip:** cursor (3,2) → row 2 is coloured for x 0–11 with no wrap to x≈2047; column 3 is coloured for y 0–10.
- **Tear-free update:** `cursor_wr` with (200,200) mid-frame → current frame still shows the old cursor; the next frame shows the new one. `cursor_wr` in the same cycle as the vsync edge → takes effect one frame later.
- **Underflow:** three underflow pulses → count=3, sticky=1. `uflow_clr` coincident with a 4th pulse → count=0, sticky=0.
- **Macro off:** build without `VGA_OVERLAY_CURSOR_EN` and repeat the crosshair stimulus → output is identical to the input delayed 2 cycles.
